// File: rtl/vedic_seq_mult8.sv
// vedic_seq_mult8: 8x8 unsigned sequential multiplier built on an external 2x2 Vedic core
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b operand handshake;
// pp_a/pp_b digits out to the 2x2 core, pp_p its combinational partial product back;
// out_valid/out_ready/product result handshake; busy high outside IDLE.
// Optional macro VEDIC_SEQ_ZERO_SKIP_EN: a zero operand goes straight to DONE with product 0.
module vedic_seq_mult8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [1:0]  pp_a,
  output logic [1:0]  pp_b,
  input  logic [3:0]  pp_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] a_reg, b_reg;
  logic [15:0] acc, acc_nx;
  logic [3:0] idx, sh;
  logic zero;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
  assign zero = (a == 8'h00) || (b == 8'h00);
`else
  assign zero = 1'b0;
`endif
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  // digit weight is 4^(i+j), i.e. a left shift of 2*(i+j)
  assign sh     = {{1'b0, idx[1:0]} + {1'b0, idx[3:2]}, 1'b0};
  assign acc_nx = acc + ({12'h000, pp_p} << sh);
  always_comb begin
    pp_a = state == CALC ? 2'(a_reg >> {idx[1:0], 1'b0}) : 2'b00;
    pp_b = state == CALC ? 2'(b_reg >> {idx[3:2], 1'b0}) : 2'b00;
    state_nx = state;
    if (state == IDLE && in_valid) state_nx = zero ? DONE : CALC;
    else if (state == CALC && idx == 4'hF) state_nx = DONE;
    else if (state == DONE && out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      idx     <= '0;
      product <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        a_reg <= a;
        b_reg <= b;
        acc   <= '0;
        idx   <= '0;
        if (zero) product <= '0;
      end else if (state == CALC) begin
        acc <= acc_nx;
        idx <= idx + 4'd1;
        if (idx == 4'hF) product <= acc_nx;
      end
    end
  end
endmodule

// File: tb/tb_vedic_seq_mult8.sv
// tb_vedic_seq_mult8: randomized self-checking bench for vedic_seq_mult8 against a*b
module tb_vedic_seq_mult8;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic in_ready, out_valid, busy;
  logic [1:0] pp_a, pp_b;
  logic [3:0] pp_p;
  logic [15:0] product;
  int n_chk = 0, n_fail = 0;

  vedic_seq_mult8 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .pp_a(pp_a), .pp_b(pp_b), .pp_p(pp_p),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  assign pp_p = 4'(pp_a * pp_b);
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_latency(input logic [7:0] x, input logic [7:0] y);
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
    if (x == 8'h00 || y == 8'h00) return 1;
`endif
    return 17;
  endfunction

  task automatic wait_result(input logic [7:0] x, input logic [7:0] y);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_latency(x, y));
    check("product", product, {8'h00, x} * {8'h00, y});
    check("done_in_ready", in_ready, 0);
    check("done_pp", {pp_a, pp_b}, 0);
  endtask

  task automatic handshake(input logic [15:0] exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after", out_valid, 0);
    check("busy_after", busy, 0);
    check("product_kept", product, exp);
  endtask

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input int hold);
    logic [15:0] exp = {8'h00, x} * {8'h00, y};
    check("idle_in_ready", in_ready, 1);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
    wait_result(x, y);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_product", product, exp);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    handshake(exp);
  endtask

  initial begin
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    check("rst_pp", {pp_a, pp_b}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(8'd3, 8'd5, 0);
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'hA5, 8'h3C, 5);
    run_op(8'h00, 8'h80, 0);
    run_op(8'h80, 8'h00, 1);
    // abort mid-CALC
    a = 8'h12; b = 8'h34; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_product", product, 0);
    check("abort_pp", {pp_a, pp_b}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(8'd7, 8'd9, 0);
    // in_valid held high while busy with a changing pair
    a = 8'h21; b = 8'h43; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h5B; b = 8'h6D;
    wait_result(8'h21, 8'h43);
    handshake(16'(8'h21 * 16'h43));
    check("second_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("second_busy", busy, 1);
    wait_result(8'h5B, 8'h6D);
    handshake(16'(8'h5B * 16'h6D));
    for (int k = 0; k < 24; k++) begin
      logic [7:0] x = 8'($urandom), y = 8'($urandom);
      if ($urandom_range(0, 5) == 0) x = 8'h00;
      run_op(x, y, int'($urandom_range(0, 3)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
